// File: rtl/paddle_pkg.sv
// paddle_pkg: shared state encoding and screen geometry for the paddle AI.
package paddle_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        HOLD = 3'd2,
        UP   = 3'd3,
        DOWN = 3'd4
    } ai_state_t;
    localparam int SCREEN_H     = 480;
    localparam int CENTER_Y     = 240;
    localparam int PADDLE_MAX_Y = 479;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle pulse every PERIOD cycles, restarted by clr.
module tick_gen #(
    parameter int PERIOD = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = PERIOD > 1 ? $clog2(PERIOD) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = !clr && cnt_q == W'(PERIOD - 1);
    always_comb cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/paddle_ai.sv
// paddle_ai: tracks the ball (or screen centre) with periodic decisions and a reaction delay,
// producing active-low paddle move requests.
module paddle_ai
    import paddle_pkg::*;
#(
    parameter int DECIDE_CYCLES = 1024,
    parameter int REACT_CYCLES  = 65536,
    parameter int DEADBAND      = 8,
    parameter int HALF_H        = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] ball_y,
    input  logic       ball_toward,
    input  logic [9:0] paddle_y,
    output logic       mv_up_n,
    output logic       mv_down_n,
    output logic [2:0] state
);
    localparam int RW = $clog2(REACT_CYCLES > 1 ? REACT_CYCLES : 2);
    localparam logic signed [11:0] DB = 12'(DEADBAND);
    ai_state_t state_q, state_d, decide;
    logic [RW-1:0] react_q, react_d;
    logic tow_q, up_q, dn_q, tick;
    logic [9:0] target;
    logic signed [11:0] err;
    tick_gen #(.PERIOD(DECIDE_CYCLES)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!en || state_q == IDLE),
        .tick (tick)
    );
    assign target = ball_toward ? ball_y : 10'(CENTER_Y);
    assign err    = $signed({2'b00, target}) - $signed({2'b00, paddle_y}) - $signed(12'(HALF_H));
    assign decide = err > DB ? DOWN : err < -DB ? UP : HOLD;
    // Priority: disable, wake from idle, ball turning toward us, reaction wait, tick decision.
    always_comb begin
        state_d = state_q;
        react_d = react_q;
        if (!en) state_d = IDLE;
        else if (state_q == IDLE) state_d = HOLD;
        else if (ball_toward && !tow_q) begin
            state_d = WAIT;
            react_d = RW'(REACT_CYCLES - 1);
        end else if (state_q == WAIT) begin
            if ((!ball_toward && tow_q) || react_q == '0) state_d = HOLD;
            else react_d = react_q - RW'(1);
        end else if (tick) state_d = decide;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            react_q <= '0;
            tow_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            react_q <= react_d;
            tow_q   <= ball_toward;
            up_q    <= state_d == UP;
            dn_q    <= state_d == DOWN;
        end
    // Edge-of-screen limits veto movement regardless of the FSM.
    assign mv_up_n   = !(up_q && paddle_y != 10'd0);
    assign mv_down_n = !(dn_q && paddle_y < 10'(PADDLE_MAX_Y));
    assign state     = state_q;
endmodule

// File: doc/paddle_ai.md
PADDLE_AI -- requirements
Module: paddle_ai

Interface
REQ-001 Parameter DECIDE_CYCLES, default 1024: clk cycles between tracking decisions.
REQ-002 Parameter REACT_CYCLES, default 65536: reaction delay in clk cycles after the ball turns toward this paddle.
REQ-003 Parameter DEADBAND, default 8: pixel error magnitude treated as on-target.
REQ-004 Parameter HALF_H, default 32: offset in pixels from paddle_y to the paddle centre.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 en  in  1  high = AI drives the paddle; low = AI idle.
REQ-008 ball_y  in  10  ball vertical position in pixels, 0..479.
REQ-009 ball_toward  in  1  high while the ball moves toward this paddle.
REQ-010 paddle_y  in  10  current paddle position, fed back from the paddle block.
REQ-011 mv_up_n  out  1  active-low move-up request, same polarity as the paddle button inputs.
REQ-012 mv_down_n  out  1  active-low move-down request.
REQ-013 state  out  3  current FSM state, for debug.

Function
REQ-014 FSM states: IDLE, WAIT, HOLD, UP, DOWN. The encoding comes from the shared package.
REQ-015 The decision tick shall pulse high for 1 clk every DECIDE_CYCLES cycles, counted from a reset or from the cycle en rises.
REQ-016 Target shall be ball_y when ball_toward=1, else CENTER_Y (240).
REQ-017 Error shall be target minus (paddle_y + HALF_H), computed as 12-bit signed with no truncation or wrap.
REQ-018 On a tick in HOLD, UP or DOWN, next state shall be:
- HOLD if |error| <= DEADBAND;
- DOWN if error > DEADBAND;
- UP if error < -DEADBAND.
REQ-019 Between ticks, HOLD, UP and DOWN shall keep their state, except as given by REQ-020 and REQ-023.
REQ-020 Each clk, ball_toward is registered. A 0->1 change seen while not in IDLE shall force WAIT on the next edge and load the reaction counter with REACT_CYCLES-1. This overrides a same-cycle tick.
REQ-021 WAIT shall decrement the reaction counter every clk, ignore ticks, and go to HOLD on the edge after the counter reaches 0.
REQ-022 A ball_toward 1->0 change in WAIT shall leave WAIT early and go to HOLD on the next edge.
REQ-023 en=0 shall force IDLE on the next edge from any state. In IDLE with en=1, the FSM shall go to HOLD on the next edge and restart the tick counter.
REQ-024 Outputs shall be registered and decoded from the registered state:
- mv_down_n=0 only in DOWN;
- mv_up_n=0 only in UP;
- otherwise both are 1.
REQ-025 Both outputs shall never be low in the same cycle.
REQ-026 Boundary rules override the FSM decode: mv_down_n shall be 1 while paddle_y >= 479, and mv_up_n shall be 1 while paddle_y == 0.
REQ-027 Latency: outputs shall reflect a tick decision on the clk edge that ends the tick cycle, i.e. 1 cycle after the tick.

Reset
REQ-028 Asynchronous assertion of rst_n shall set state=IDLE, mv_up_n=1, mv_down_n=1, both counters to 0, and the registered ball_toward to 0.
REQ-029 Reset asserted mid-WAIT or mid-move shall abandon the operation immediately. After release, the block shall behave as after power-up.

Structure
REQ-030 Package paddle_pkg shall hold:
- the state enum (ai_state_t);
- SCREEN_H=480;
- CENTER_Y=240;
- PADDLE_MAX_Y=479.
REQ-031 Sub-module tick_gen (parameter PERIOD, ports clk, rst_n, clr, tick) shall produce the decision tick. The rest of the logic is in a single module.

Verification
REQ-032 Parameters for all scenarios: DECIDE_CYCLES=4, REACT_CYCLES=8, DEADBAND=4, HALF_H=16.
REQ-033 Scenario: en=1, ball_toward=0, paddle_y=100 -> first tick selects DOWN (error=124), mv_down_n=0 one cycle after the tick, mv_up_n=1.
REQ-034 Scenario: ball_toward 0->1 with ball_y=50, paddle_y=200 -> WAIT for 8 cycles with both outputs 1, then HOLD, then UP (error=-166) on the next tick.
REQ-035 Scenario: paddle_y=222, ball_toward=0 (error=2) -> HOLD on every tick, both outputs stay 1.
REQ-036 Scenario: state DOWN with paddle_y=479 -> mv_down_n=1; state UP with paddle_y=0 -> mv_up_n=1.
REQ-037 Scenario: en dropped during DOWN -> IDLE and both outputs 1 on the next edge. rst_n pulsed mid-WAIT -> IDLE immediately, outputs 1.
REQ-038 The bench shall check mv_up_n|mv_down_n == 1 on every cycle of every scenario.
